// File: rtl/parcel_pkg.sv
// Shared definitions for the parcel-locker keypad consumers.
package parcel_pkg;

   localparam int DIGIT_W   = 4;
   localparam int DIGIT_MAX = 7;

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      DONE
   } code_entry_state_t;

endpackage

// File: rtl/code_entry_key_edge.sv
// key_edge: turns a key-held level into a one-cycle press pulse.
// The history register resets to 1, so a key already held when reset
// releases is not seen as a press.
module key_edge (
   input  logic clk_1k,
   input  logic rst_n,
   input  logic plus,
   output logic press
);

   logic held_q;
   logic held_d;

   // The history register follows the key level every cycle.
   always_comb begin
      held_d = plus;
   end

   // History register; resets high to suppress a press on reset release.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) held_q <= 1'b1;
      else        held_q <= held_d;
   end

   assign press = plus & ~held_q;

endmodule

// File: rtl/code_entry.sv
// code_entry: assembles a fixed-length pickup code from keypad presses
// and hands it to the locker controller with a valid/ack handshake.
// Optional feature macro: CODE_ENTRY_TIMEOUT_EN (inactivity timeout).
module code_entry
   import parcel_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int TIMEOUT_MS = 5000
) (
   input  logic                      clk_1k,
   input  logic                      rst_n,
   input  logic [DIGIT_W-1:0]        num_in,
   input  logic                      plus,
   input  logic                      clr,
   input  logic                      code_ack,
   output logic [DIGIT_W*DIGITS-1:0] code,
   output logic                      code_valid,
   output logic [3:0]                digit_cnt,
   output logic [DIGIT_W-1:0]        last_digit,
   output logic                      timeout
);

   localparam int CODE_W = DIGIT_W * DIGITS;

   // Reject illegal configurations at elaboration.
   if (DIGITS < 1 || DIGITS > 8 || TIMEOUT_MS < 2) begin : g_bad_param
      $error("code_entry: DIGITS must be 1..8 and TIMEOUT_MS at least 2");
   end

   code_entry_state_t   state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DIGIT_W-1:0]  last_q, last_d;
   logic                press;

   key_edge u_key_edge (
      .clk_1k (clk_1k),
      .rst_n  (rst_n),
      .plus   (plus),
      .press  (press)
   );

`ifdef CODE_ENTRY_TIMEOUT_EN
   localparam int IDLE_W = $clog2(TIMEOUT_MS);
   localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_MS - 1);

   logic [IDLE_W-1:0]   idle_q, idle_d;
   logic                timeout_q, timeout_d;
`endif

   // Next-state and datapath: clr, then ack in DONE, then press, then timeout.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
`ifdef CODE_ENTRY_TIMEOUT_EN
      timeout_d = 1'b0;
      idle_d    = '0;
`endif
      if (clr) begin
         state_d = IDLE;
         code_d  = '0;
         cnt_d   = '0;
      end else if (state_q == DONE && code_ack) begin
         state_d = IDLE;
         code_d  = '0;
         cnt_d   = '0;
      end else if (press && state_q != DONE) begin
         code_d  = (code_q << DIGIT_W) | CODE_W'(num_in);
         last_d  = num_in;
         cnt_d   = cnt_q + 4'd1;
         state_d = (cnt_q == 4'(DIGITS - 1)) ? DONE : ENTRY;
`ifdef CODE_ENTRY_TIMEOUT_EN
      end else if (state_q == ENTRY) begin
         if (idle_q == IDLE_LIMIT) begin
            state_d   = IDLE;
            code_d    = '0;
            cnt_d     = '0;
            timeout_d = 1'b1;
         end else begin
            idle_d = idle_q + 1'b1;
         end
`endif
      end
   end

   // Entry state, code register and digit echo.
   // NOTE: all flops here are control/status registers, so every one takes the async reset.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         code_q  <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
      end
   end

`ifdef CODE_ENTRY_TIMEOUT_EN
   // Inactivity counter and one-cycle timeout pulse.
   always_ff @(posedge clk_1k or negedge rst_n) begin
      if (!rst_n) begin
         idle_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign code       = code_q;
   assign code_valid = (state_q == DONE);
   assign digit_cnt  = cnt_q;
   assign last_digit = last_q;

endmodule
